// File: rtl/ky32_pkg.sv
// ============================================================================
// Module      : ky32_pkg
// Description : Shared types and constants for the KY32 serial link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ky32_pkg;

    localparam int KY32_WORD_W = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ky32_state_t;

endpackage

`default_nettype wire

// File: rtl/ky32_shift_reg.sv
// ============================================================================
// Module      : ky32_shift_reg
// Description : Parallel-load shift register, zero fill, direction select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ky32_shift_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic             dir,
    input  logic [WIDTH-1:0] d,
    output logic             ser_out
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_next;

    // dir=1 moves data toward bit 0 (LSB out), dir=0 toward bit WIDTH-1.
    always_comb begin
        if (dir) begin
            w_shifted = {1'b0, r_q[WIDTH-1:1]};
        end else begin
            w_shifted = {r_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        w_next = r_q;
        if (load) begin
            w_next = d;
        end else if (shift_en) begin
            w_next = w_shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign ser_out = dir ? r_q[0] : r_q[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/ky32_serializer.sv
// ============================================================================
// Module      : ky32_serializer
// Description : Bit-serial transmitter with load/serial handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ky32_serializer
    import ky32_pkg::*;
#(
    parameter int WIDTH     = KY32_WORD_W,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_bit,
    output logic             ser_last,
    output logic             busy
);

    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    ky32_state_t      r_state;
    ky32_state_t      w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load_fire;
    logic             w_ser_fire;
    logic             w_sreg_out;

    assign w_load_fire = load_valid & load_ready;
    assign w_ser_fire  = ser_valid & ser_ready;

    // Reload during the final fire keeps frames back-to-back.
    assign load_ready  = (r_state == IDLE) | (ser_last & ser_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_load_fire) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_ser_fire && ser_last) begin
                    w_next_state = load_valid ? SHIFT : IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        ser_valid = 1'b0;
        busy      = 1'b0;
        ser_last  = 1'b0;
        ser_bit   = 1'b0;
        if (r_state == SHIFT) begin
            ser_valid = 1'b1;
            busy      = 1'b1;
            ser_last  = (r_cnt == c_last);
            ser_bit   = w_sreg_out;
        end
    end

    // Counter returns to zero after the last bit rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_load_fire) begin
            r_cnt <= '0;
        end else if (w_ser_fire) begin
            r_cnt <= ser_last ? '0 : r_cnt + 1'b1;
        end
    end

    ky32_shift_reg #(
        .WIDTH (WIDTH)
    ) u_sreg (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load_fire),
        .shift_en (w_ser_fire),
        .dir      (LSB_FIRST),
        .d        (load_data),
        .ser_out  (w_sreg_out)
    );

endmodule

`default_nettype wire
